// File: rtl/analog_force_driver.sv
// analog_force_driver: ramps a forced node code to a target, holds, releases.
// Define ANALOG_FORCE_CLAMP_EN to clamp target and ramp to [CODE_MIN, CODE_MAX].
module analog_force_driver #(
  parameter int CODE_W   = 12,
  parameter int DWELL_W  = 8,
  parameter int HOLD_W   = 16,
  parameter int CODE_MIN = 0,
  parameter int CODE_MAX = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CODE_W-1:0]  req_target,
  input  logic [CODE_W-1:0]  req_step,
  input  logic [DWELL_W-1:0] req_dwell,
  input  logic [HOLD_W-1:0]  req_hold,
  input  logic               release_req,
  output logic               force_en,
  output logic [CODE_W-1:0]  force_code,
  output logic               ramping,
  output logic               done
);

`ifdef ANALOG_FORCE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  localparam logic [CODE_W-1:0] LO = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] HI = CODE_W'(CODE_MAX);

  typedef enum logic [1:0] {
    IDLE, RAMP, HOLD, RELEASE
  } state_t;

  state_t state, state_nx;

  logic [CODE_W-1:0]  code_q, tgt_q, step_q;
  logic [CODE_W-1:0]  diff, nxt;
  logic [DWELL_W-1:0] dwell_q, dcnt_q;
  logic [HOLD_W-1:0]  hold_q, hcnt_q;
  logic               accept, rel, slot, land;
  logic               expire;

  function automatic logic [CODE_W-1:0] clamp(
    input logic [CODE_W-1:0] v
  );
    if (!CLAMP) return v;
    if (v < LO) return LO;
    if (v > HI) return HI;
    return v;
  endfunction

  assign rel    = release_req &&
                  (state == RAMP || state == HOLD);
  assign accept = req_valid && req_ready;
  assign slot   = (dcnt_q == '0);
  assign diff   = (code_q >= tgt_q) ? code_q - tgt_q
                                    : tgt_q - code_q;
  assign land   = (step_q == '0) || (diff <= step_q);
  assign expire = (hold_q != '0) &&
                  (hcnt_q <= HOLD_W'(1));

  // Landing rule keeps the stepped code on the near side of the target.
  always_comb begin
    nxt = tgt_q;
    if (!land) begin
      if (tgt_q > code_q) nxt = clamp(code_q + step_q);
      else                nxt = clamp(code_q - step_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RAMP;
      RAMP: begin
        if (rel)               state_nx = RELEASE;
        else if (slot && land) state_nx = HOLD;
      end
      HOLD: begin
        if (rel)         state_nx = RELEASE;
        else if (accept) state_nx = RAMP;
        else if (expire) state_nx = RELEASE;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) ||
                 (state == HOLD && !release_req);
    force_en   = (state == RAMP) || (state == HOLD);
    ramping    = (state == RAMP);
    done       = (state == RELEASE);
    force_code = code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
    end else if (accept) begin
      tgt_q   <= clamp(req_target);
      step_q  <= req_step;
      dwell_q <= req_dwell;
      dcnt_q  <= req_dwell;
      hold_q  <= req_hold;
    end else if (state == RAMP && !rel) begin
      if (slot) begin
        code_q <= nxt;
        dcnt_q <= dwell_q;
        if (land) hcnt_q <= hold_q;
      end else begin
        dcnt_q <= dcnt_q - DWELL_W'(1);
      end
    end else if (state == HOLD && !rel) begin
      if (hcnt_q != '0) hcnt_q <= hcnt_q - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_analog_force_driver.sv
// tb_analog_force_driver: random and directed requests checked by a
// queue-based scoreboard of expected code changes and done pulses.
module tb_analog_force_driver;

  localparam int CW = 12;
  localparam int DW = 8;
  localparam int HW = 16;
`ifdef ANALOG_FORCE_CLAMP_EN
  localparam int CMIN = 0;
  localparam int CMAX = 3000;
`else
  localparam int CMIN = 0;
  localparam int CMAX = 4095;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_target;
  logic [CW-1:0] req_step;
  logic [DW-1:0] req_dwell;
  logic [HW-1:0] req_hold;
  logic          release_req;
  logic          force_en;
  logic [CW-1:0] force_code;
  logic          ramping;
  logic          done;

  analog_force_driver #(
    .CODE_W(CW), .DWELL_W(DW), .HOLD_W(HW),
    .CODE_MIN(CMIN), .CODE_MAX(CMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_step(req_step),
    .req_dwell(req_dwell), .req_hold(req_hold),
    .release_req(release_req),
    .force_en(force_en), .force_code(force_code),
    .ramping(ramping), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int code;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  cur   = 0;
  int  nchk  = 0;
  int  npass = 0;
  int  prev  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act,
                       input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic see_event(input int kind, input int code);
    ev_t e;
    nchk++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_event: kind %0d code %0d cyc %0d",
               kind, code, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind == kind && e.code == code && e.cyc == cyc)
        npass++;
      else
        $display("FAIL event: got k%0d c%0d @%0d expected k%0d c%0d @%0d",
                 kind, code, cyc, e.kind, e.code, e.cyc);
    end
  endtask

  // Monitor: every code change and every done pulse is one event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 0;
    end else begin
      if (int'(force_code) != prev) begin
        see_event(0, int'(force_code));
        prev = int'(force_code);
      end
      if (done) begin
        see_event(1, int'(force_code));
        check("done_force_en", int'(force_en), 0);
      end
    end
  end

  function automatic int clampv(input int v);
`ifdef ANALOG_FORCE_CLAMP_EN
    if (v < CMIN) return CMIN;
    if (v > CMAX) return CMAX;
`endif
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input int c, input int e);
    q.push_back('{k, c, e});
  endtask

  // Issue a request; ab>0 releases ab cycles after accept, ab<0 at random.
  task automatic issue(input int tgt, input int st, input int dw,
                       input int hd, input int ab, output int land);
    int a, t, c, n, e, off;
    int codes[$];
    req_target = CW'(tgt);
    req_step   = CW'(st);
    req_dwell  = DW'(dw);
    req_hold   = HW'(hd);
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    req_valid = 1'b0;
    t = clampv(tgt);
    c = cur;
    do begin
      if (st == 0 || (t > c ? t - c : c - t) <= st) c = t;
      else if (t > c) c = clampv(c + st);
      else c = clampv(c - st);
      codes.push_back(c);
    end while (c != t);
    n = codes.size();
    land = a + (dw + 1) * n;
    off = ab;
    if (ab < 0) off = $urandom_range(1, (dw + 1) * n);
    for (int i = 0; i < n; i++) begin
      e = a + (dw + 1) * (i + 1);
      if (off > 0 && e >= a + off) break;
      if (codes[i] != cur) push(0, codes[i], e);
      cur = codes[i];
    end
    if (off > 0) begin
      push(1, cur, a + off);
      wait_cyc(a + off - 1);
      release_req = 1'b1;
      @(posedge clk);
      #1;
      release_req = 1'b0;
      @(posedge clk);
      #1;
      land = -1;
    end
  endtask

  task automatic finish_hold(input int hd, input int land);
    push(1, cur, land + hd);
    wait_cyc(land + hd + 1);
  endtask

  task automatic hold_release(input int land, input int extra);
    wait_cyc(land + extra);
    push(1, cur, cyc + 1);
    release_req = 1'b1;
    @(posedge clk);
    #1;
    release_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string nm);
    check({nm, "_force_en"},   int'(force_en),   0);
    check({nm, "_force_code"}, int'(force_code), 0);
    check({nm, "_ramping"},    int'(ramping),    0);
    check({nm, "_done"},       int'(done),       0);
    check({nm, "_req_ready"},  int'(req_ready),  1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cyc %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int land, x, mode, hd;
    bit in_hold;
    rst_n = 1'b0;
    req_valid = 1'b0;
    release_req = 1'b0;
    req_target = '0;
    req_step = '0;
    req_dwell = '0;
    req_hold = '0;
    repeat (2) @(posedge clk);
    #1;
    check_rst("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(100, 30, 1, 4, 0, land);
    finish_hold(4, land);

    issue(2000, 0, 3, 0, 0, land);
    hold_release(land, 55);

    issue(100, 50, 0, 0, 0, land);
    wait_cyc(land + 3);
    issue(40, 25, 0, 0, 0, land);
    wait_cyc(land + 2);
    issue(40, 10, 2, 2, 0, land);
    finish_hold(2, land);

    issue(500, 0, 0, 0, 0, land);
    wait_cyc(land + 2);
    x = cyc;
    release_req = 1'b1;
    req_valid = 1'b1;
    req_target = CW'(900);
    req_step = '0;
    #1;
    check("prio_req_ready", int'(req_ready), 0);
    push(1, cur, x + 1);
    @(posedge clk);
    #1;
    release_req = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("prio_force_en", int'(force_en), 0);
    check("prio_ramping", int'(ramping), 0);
    check("prio_idle_ready", int'(req_ready), 1);

    issue(0, 0, 0, 1, 0, land);
    finish_hold(1, land);
    issue(200, 30, 1, 0, 5, land);
    check("abort_code", int'(force_code), 60);

    issue(3000, 100, 2, 5, 0, land);
    wait_cyc(cyc + 7);
    @(negedge clk);
    #1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    rst_n = 1'b0;
    #1;
    check_rst("midramp_reset");
    cur = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(4000, 0, 0, 2, 0, land);
    finish_hold(2, land);

    in_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      hd = (mode == 0) ? $urandom_range(1, 6) : 0;
      issue($urandom_range(0, 4095),
            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(40, 800),
            $urandom_range(0, 3), hd,
            (mode == 3) ? -1 : 0, land);
      in_hold = 1'b0;
      if (mode == 0) finish_hold(hd, land);
      else if (mode == 1) hold_release(land, $urandom_range(0, 20));
      else if (mode == 2) begin
        wait_cyc(land + $urandom_range(0, 5));
        in_hold = 1'b1;
      end
    end
    if (in_hold) hold_release(cyc, 0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
